// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, bit-time counter width, frame length helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package uart_pkg;

  // Receive/transmit engine frame states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2
  } state_t;

  // Width of the bit-time counter and of the k (bit time - 1) input
  localparam int BTW = 19;

  // Number of samples after the start bit: data bits, optional parity, stop.
  // Returns 8..10.
  function automatic logic [3:0] frame_bits(input logic eight, input logic pen);
    return 4'd8 + {3'd0, eight} + {3'd0, pen};
  endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-time counter for the UART receiver with half-bit and full-bit compares against k.
// Latency: compare outputs are combinational from the registered count.
// Backpressure: none; counts whenever enabled, clear has priority over enable.
module rx_bit_timer
  import uart_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           i_en,
  input  logic           i_clr,
  input  logic [BTW-1:0] i_k,
  output logic           o_half,
  output logic           o_full
);

  logic [BTW-1:0] r_cnt;

  // Free-running count while enabled; cleared at every sample point and in idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Half-bit point locates the middle of the start bit; full-bit point spaces later samples
  assign o_half = (r_cnt == (i_k >> 1));
  assign o_full = (r_cnt == i_k);

endmodule

// File: rtl/receive_engine.sv
// UART receive engine: synchronizes rx, reassembles start/data/parity/stop frames, flags errors.
// Latency: rx_s is 2 clocks behind rx; outputs update 1 clock after the stop-bit sample.
// Backpressure: none; a frame completing while rx_rdy is still set overwrites the byte and sets ovf.
module receive_engine
  import uart_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           rx,
  input  logic           eight,
  input  logic           pen,
  input  logic           ohel,
  input  logic [BTW-1:0] k,
  input  logic           read,
  output logic [7:0]     rx_data,
  output logic           rx_rdy,
  output logic           perr,
  output logic           ferr,
  output logic           ovf
);

  // Synchronizer and edge-detect flops
  logic       r_rx_meta;
  logic       r_rx_s;
  logic       r_rx_s_d1;

  // Frame FSM
  state_t     r_state;
  state_t     w_next_state;

  // Bit timer control/status
  logic       w_tmr_en;
  logic       w_tmr_clr;
  logic       w_half;
  logic       w_full;

  // Sample capture
  logic [3:0] r_bitcnt;
  logic [9:0] r_shift;
  logic [9:0] w_shift_next;
  logic       w_sample;
  logic       w_done;
  logic [3:0] w_nbits;

  // Field extraction and checks
  logic [9:0] w_frame;
  logic [7:0] w_data;
  logic       w_par_bit;
  logic       w_stop;
  logic       w_par_calc;
  logic       w_perr_new;
  logic       w_ferr_new;

  // Output registers
  logic [7:0] r_rx_data;
  logic       r_rx_rdy;
  logic       r_perr;
  logic       r_ferr;
  logic       r_ovf;

  // Two-flop synchronizer plus one delay flop for falling-edge detect; idle-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_s_d1 <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_rx_s_d1 <= r_rx_s;
    end
  end

  rx_bit_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_tmr_en),
    .i_clr  (w_tmr_clr),
    .i_k    (k),
    .o_half (w_half),
    .o_full (w_full)
  );

  assign w_nbits = frame_bits(eight, pen);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state and per-cycle controls: timer enable/clear, sample strobe, frame done
  always_comb begin
    w_next_state = r_state;
    w_tmr_en     = 1'b0;
    w_tmr_clr    = 1'b0;
    w_sample     = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        w_tmr_clr = 1'b1;
        // Requires a high-to-low transition, so a line stuck low never restarts a frame
        if (r_rx_s_d1 && !r_rx_s) begin
          w_next_state = START;
        end
      end
      START: begin
        w_tmr_en = 1'b1;
        if (w_half) begin
          w_tmr_clr    = 1'b1;
          // High at mid-start means the falling edge was a glitch
          w_next_state = r_rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        w_tmr_en = 1'b1;
        if (w_full) begin
          w_tmr_clr = 1'b1;
          w_sample  = 1'b1;
          if (r_bitcnt == (w_nbits - 4'd1)) begin
            w_done       = 1'b1;
            w_next_state = IDLE;
          end
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Samples enter at the MSB so the first bit drifts toward the LSB
  assign w_shift_next = {r_rx_s, r_shift[9:1]};

  // Bit counter and shift register; the counter is held at zero outside DATA
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bitcnt <= '0;
      r_shift  <= '0;
    end else if (r_state != DATA) begin
      r_bitcnt <= '0;
    end else if (w_sample) begin
      r_bitcnt <= r_bitcnt + 4'd1;
      r_shift  <= w_shift_next;
    end
  end

  // Right-align the frame (including the stop sample taken this cycle) so bit 0 is the first data bit
  assign w_frame    = w_shift_next >> (4'd10 - w_nbits);
  assign w_data     = {eight ? w_frame[7] : 1'b0, w_frame[6:0]};
  assign w_par_bit  = eight ? w_frame[8] : w_frame[7];
  assign w_stop     = w_frame[w_nbits - 4'd1];
  // Bit 7 of w_data is 0 in 7-bit mode, so XOR over all eight is the 7-bit parity too
  assign w_par_calc = ^w_data;
  assign w_perr_new = pen & (w_par_bit != (w_par_calc ^ ohel));
  assign w_ferr_new = ~w_stop;

  // Processor-side holding registers; a frame completion wins over read, read clears status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_data <= 8'h00;
      r_rx_rdy  <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (w_done) begin
      r_rx_data <= w_data;
      r_perr    <= w_perr_new;
      r_ferr    <= w_ferr_new;
      r_rx_rdy  <= 1'b1;
      // A read in the same cycle consumed the old byte, so nothing was lost
      r_ovf     <= r_rx_rdy & ~read;
    end else if (read) begin
      r_rx_rdy  <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovf     <= 1'b0;
    end
  end

  assign rx_data = r_rx_data;
  assign rx_rdy  = r_rx_rdy;
  assign perr    = r_perr;
  assign ferr    = r_ferr;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_receive_engine.sv
// Self-checking bench for receive_engine with a scoreboard of expected received bytes/flags.
// Latency: frames driven at 16 clocks/bit; outputs compared when the DUT presents a new result.
// Backpressure: the bench controls read and exercises overrun and read/done coincidence.
module tb_receive_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        eight;
  logic        pen;
  logic        ohel;
  logic [18:0] k;
  logic        read;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        perr;
  logic        ferr;
  logic        ovf;

  always #5 clk = ~clk;

  receive_engine dut (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx),
    .eight   (eight),
    .pen     (pen),
    .ohel    (ohel),
    .k       (k),
    .read    (read),
    .rx_data (rx_data),
    .rx_rdy  (rx_rdy),
    .perr    (perr),
    .ferr    (ferr),
    .ovf     (ovf)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovf;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive start, data (LSB first), optional parity, stop; 16 clocks per bit. Call at a negedge.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop);
    logic [10:0] bits;
    int          nb;
    bits    = '0;
    bits[0] = 1'b0;
    for (int i = 0; i < 7; i++) bits[1+i] = d[i];
    nb = 8;
    if (eight) begin
      bits[8] = d[7];
      nb      = 9;
    end
    if (pen) begin
      bits[nb] = pbit;
      nb++;
    end
    bits[nb] = stop;
    nb++;
    for (int i = 0; i < nb; i++) begin
      rx = bits[i];
      repeat (16) @(negedge clk);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic e_perr, input logic e_ferr, input logic e_ovf);
    exp_t e;
    e.data = eight ? d : {1'b0, d[6:0]};
    e.perr = e_perr;
    e.ferr = e_ferr;
    e.ovf  = e_ovf;
    sb_q.push_back(e);
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic pbit, input logic stop,
                              input logic e_perr, input logic e_ferr, input logic e_ovf);
    push_exp(d, e_perr, e_ferr, e_ovf);
    send_frame(d, pbit, stop);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_read();
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
  endtask

  // Monitor: a new result is a rising rx_rdy, or changed byte/flags while rx_rdy stays high
  logic        p_rdy = 1'b0;
  logic [10:0] p_vec = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rx_rdy && (!p_rdy || {rx_data, perr, ferr, ovf} != p_vec)) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_output", sb_q.size(), 1);
      end else begin
        e = sb_q.pop_front();
        check_val("rx_data", rx_data, e.data);
        check_val("perr", perr, e.perr);
        check_val("ferr", ferr, e.ferr);
        check_val("ovf", ovf, e.ovf);
      end
    end
    p_rdy = rx_rdy;
    p_vec = {rx_data, perr, ferr, ovf};
  end

  initial begin
    rst   = 1'b1;
    rx    = 1'b1;
    read  = 1'b0;
    eight = 1'b0;
    pen   = 1'b0;
    ohel  = 1'b0;
    k     = 19'd15;
    repeat (3) @(negedge clk);
    check_val("rst_rx_data", rx_data, 8'h00);
    check_val("rst_rx_rdy", rx_rdy, 0);
    check_val("rst_flags", {perr, ferr, ovf}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 7N1 0x55 with output timing: stop sample in cycle after edge 138, update at edge 139
    push_exp(8'h55, 1'b0, 1'b0, 1'b0);
    fork
      send_frame(8'h55, 1'b0, 1'b1);
      begin
        repeat (138) @(negedge clk);
        check_val("rdy_before_update", rx_rdy, 0);
        @(negedge clk);
        check_val("rdy_after_update", rx_rdy, 1);
      end
    join
    rx = 1'b1;
    repeat (4) @(negedge clk);
    do_read();
    check_val("rdy_cleared_by_read", rx_rdy, 0);
    check_val("data_held_after_read", rx_data, 8'h55);

    // 8-bit even parity
    eight = 1'b1; pen = 1'b1; ohel = 1'b0;
    expect_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_read();
    expect_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    do_read();
    check_val("perr_cleared", perr, 0);

    // Odd parity, 8-bit then 7-bit
    ohel = 1'b1;
    expect_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    do_read();
    eight = 1'b0;
    expect_frame(8'h41, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    do_read();

    // Framing error, line held low afterwards, then re-armed by a high period
    eight = 1'b0; pen = 1'b0; ohel = 1'b0;
    push_exp(8'h2B, 1'b0, 1'b1, 1'b0);
    send_frame(8'h2B, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    do_read();
    check_val("ferr_cleared", ferr, 0);
    repeat (60) @(negedge clk);
    check_val("no_frame_while_low", rx_rdy, 0);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    expect_frame(8'h19, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_read();

    // Overrun: two 8N1 frames without read
    eight = 1'b1;
    expect_frame(8'h12, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_frame(8'h34, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    do_read();
    check_val("ovf_rdy_cleared", {rx_rdy, perr, ferr, ovf}, 0);

    // Read coincident with second done (8N1: done in cycle before edge 155)
    expect_frame(8'h56, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    push_exp(8'h78, 1'b0, 1'b0, 1'b0);
    fork
      send_frame(8'h78, 1'b0, 1'b1);
      begin
        repeat (154) @(negedge clk);
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
      end
    join
    rx = 1'b1;
    repeat (4) @(negedge clk);
    check_val("rdy_after_coincident_read", rx_rdy, 1);
    do_read();

    // Glitch shorter than half a bit
    eight = 1'b0;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check_val("glitch_no_rdy", rx_rdy, 0);

    // Reset mid-DATA with an unread byte held
    expect_frame(8'h6E, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    rx = 1'b0; repeat (16) @(negedge clk);
    rx = 1'b1; repeat (16) @(negedge clk);
    rx = 1'b0; repeat (16) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("midrst_rx_rdy", rx_rdy, 0);
    check_val("midrst_rx_data", rx_data, 8'h00);
    check_val("midrst_flags", {perr, ferr, ovf}, 0);
    @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    repeat (20) @(negedge clk);
    expect_frame(8'h4D, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_read();

    repeat (20) @(negedge clk);
    check_val("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/receive_engine.md
# receive_engine

Serial receive half of the full UART. Samples an asynchronous `rx` line, reassembles frames sent by the UART transmit engine (start, 7 data, optional 8th data bit, optional parity, stop), checks parity and stop bit, and presents the byte plus status flags to the processor-side read port. It shares the `eight`/`pen`/`ohel`/`k` configuration with the transmit engine.

## Interface
- No parameters. Frame format and baud are runtime inputs.
- Reset `rst` is asynchronous and active-high; the clock is `clk`.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `rx` in 1: serial input, asynchronous to `clk`; idles high.
- `eight` in 1: 1 means 8 data bits, 0 means 7 data bits.
- `pen` in 1: parity enable.
- `ohel` in 1: 1 means odd parity, 0 means even parity.
- `k` in 19: bit time is `k+1` clocks.
- `read` in 1: single-cycle pulse; processor consumed `rx_data` and the flags.
- `rx_data` out 8: received byte; bit 7 is 0 in 7-bit mode.
- `rx_rdy` out 1: a byte is available.
- `perr` out 1: parity error on the held byte.
- `ferr` out 1: framing error on the held byte (stop bit sampled low).
- `ovf` out 1: overrun; a frame completed while `rx_rdy` was already 1.

## Operation
- `rx` passes through a 2-flop synchronizer to give `rx_s`. A third flop holds `rx_s_d1`, used for falling-edge detect.
- State IDLE (reset state): bit-time counter and bit counter are held at 0.
  - Go to START on a falling edge, `rx_s_d1`=1 and `rx_s`=0.
- State START: the counter runs.
  - When the count equals `k>>1`, sample `rx_s`.
  - If the sample is 1, it was a glitch: go to IDLE with no flag change.
  - If the sample is 0, clear the counter and go to DATA.
- State DATA: each time the count equals `k`, counting from the mid-start sample:
  - sample `rx_s` into an LSB-first shift register;
  - increment the bit counter;
  - clear the bit-time counter.
- Bits after start: N = 7 + `eight` + `pen` + 1 (stop), giving 8..10.
  - After the Nth sample, pulse `done` and go to IDLE.
- Field extraction at `done`:
  - `data[6:0]` = first 7 samples.
  - `data[7]` = 8th sample if `eight`, else 0.
  - The parity bit follows the data when `pen`=1.
  - The stop bit is the last sample.
- Parity check: `p` = XOR over the 7 or 8 data bits. Expected parity bit = `p` when `ohel`=0, `~p` when `ohel`=1. `perr` = `pen` and (received bit != expected). When `pen`=0, `perr` is always 0.
- `ferr` = (stop sample == 0). The edge-detect re-arm means a line held low after a framing error starts no new frame until `rx` returns high.
- At `done`, `rx_data`, `perr` and `ferr` are loaded and `rx_rdy` is set.
  - `ovf` is set if `rx_rdy` was 1 and `read` is not asserted in the same cycle.
- On `read`: `rx_rdy`, `perr`, `ferr` and `ovf` clear. `rx_data` holds its value.
- `read` and `done` in the same cycle: new data and flags load, `rx_rdy` stays 1, `ovf`=0.
- Config inputs are assumed static during a frame. They are sampled at `done` for extraction only.

## Timing
- Reset values:
  - `rx_data`=0x00, `rx_rdy`=0, `perr`=0, `ferr`=0, `ovf`=0.
  - State IDLE, counters 0, synchronizer flops 1.
- Synchronizer latency is 2 clocks from `rx` to `rx_s`.
- Mid-start sample falls `(k>>1)+1` clocks after entering START. Each later sample is `k+1` clocks apart.
- `rx_rdy`, `rx_data` and the flags update on the clock edge after the stop-bit sample cycle (registered, 1 clock).
- The next frame's start edge is accepted from the cycle after `done`.
- `rst` asserted mid-frame: immediate return to reset values. The partial frame is discarded.
- `read` while `rx_rdy`=0 has no effect.

## Structure
- Shared package `uart_pkg`:
  - state enum {IDLE, START, DATA};
  - `BTW`=19 (bit-time width);
  - frame-length helper `frame_bits(eight, pen)`, returning 8..10.
  - The transmit engine uses the same package.
- One natural sub-module, `rx_bit_timer`:
  - a 19-bit counter with enable, clear, and half/full compare outputs against `k`.
- The FSM, shift register, extraction, parity and flag logic stay in `receive_engine`.

## Test plan
All scenarios use `k`=15 (16 clocks/bit).
- 7N1 frame of 0x55: `rx_rdy` rises 1 clock after the stop sample; `rx_data`=0x55, `perr`=`ferr`=`ovf`=0. Then `read` clears `rx_rdy`.
- 8-bit even parity (`eight`=1, `pen`=1, `ohel`=0):
  - 0xA5 with parity bit 0 gives `perr`=0.
  - The same byte with parity bit 1 gives `perr`=1 and `rx_data`=0xA5.
- 8-bit odd parity 0x3C with parity bit 1 gives `perr`=0. 7-bit odd parity 0x41 with parity bit 1 gives `perr`=0.
- Stop bit driven low gives `ferr`=1. Holding `rx` low afterwards gives no second `rx_rdy`; after `rx` goes high then low, a new frame is received.
- Overrun:
  - Two 8N1 frames 0x12 then 0x34 with no `read` give `ovf`=1 and `rx_data`=0x34; `read` clears all flags.
  - `read` coincident with the second `done` gives `ovf`=0.
- Glitch and reset:
  - `rx` low for 4 clocks (less than the half bit of 8) returns to IDLE with no `rx_rdy`.
  - `rst` pulsed mid-DATA returns all outputs to reset values; the next full frame is received correctly.
